sprite_draw_ctrl: RTL and testbench

SPRITE_DRAW_CTRL -- requirements
Module: sprite_draw_ctrl

---
 rtl/sprite_draw_ctrl.sv | 169 ++++++++++++++++
 tb/tb_sprite_draw_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_draw_ctrl.sv
// Purpose: CHIP-8 style sprite draw (DXYN, XOR with collision) and screen clear (00E0) sequencer for a 64x32 framebuffer.
// Latency: draw completes 18*n+1 cycles after the accepted start edge (n=0 -> 1 cycle); clear completes after 2049 cycles.
// Backpressure: none; start requests are sampled only in IDLE and are silently dropped while an operation is running.
//
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   draw_start        one-cycle draw request, latches sprite_x/y/n/addr
//   clear_start       one-cycle clear request; wins over a simultaneous draw
//   mem_addr          sprite byte address (registered, valid during FETCH)
//   mem_readdata      sprite byte, one cycle after mem_addr
//   fb_addr_x/y       framebuffer pixel address (registered)
//   fb_readdata       framebuffer pixel, one cycle after address
//   fb_writedata/WE   framebuffer write port (combinational from state)
//   busy/done         status; done is a one-cycle pulse in DONE
//   collision         sticky result of the most recent draw
module sprite_draw_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        draw_start,
  input  logic        clear_start,
  input  logic [5:0]  sprite_x,
  input  logic [4:0]  sprite_y,
  input  logic [3:0]  sprite_n,
  input  logic [11:0] sprite_addr,
  output logic [11:0] mem_addr,
  input  logic [7:0]  mem_readdata,
  output logic [5:0]  fb_addr_x,
  output logic [4:0]  fb_addr_y,
  output logic        fb_writedata,
  output logic        fb_WE,
  input  logic        fb_readdata,
  output logic        busy,
  output logic        done,
  output logic        collision
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LATCH  = 3'd2;
  localparam logic [2:0] S_PIX_RD = 3'd3;
  localparam logic [2:0] S_PIX_WR = 3'd4;
  localparam logic [2:0] S_CLEAR  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]  state;

  // Latched draw parameters
  logic [5:0]  x_q;
  logic [4:0]  y_q;
  logic [3:0]  n_q;
  logic [11:0] addr_q;

  // Row / column counters and current sprite row
  logic [3:0]  row;
  logic [2:0]  col;
  logic [7:0]  shreg;

  logic        last_row;
  logic        sprite_bit;

  // row+1 is compared at 5 bits so row=15, n=0 can never alias (n=0 never reaches here anyway)
  assign last_row   = (({1'b0, row} + 5'd1) == {1'b0, n_q});
  assign sprite_bit = shreg[7];

  // Status and write port are decoded straight from state so that a reset
  // (which forces IDLE asynchronously) drops fb_WE and busy in the same instant.
  assign busy         = (state != S_IDLE) && (state != S_DONE);
  assign done         = (state == S_DONE);
  assign fb_WE        = ((state == S_PIX_WR) && sprite_bit) || (state == S_CLEAR);
  assign fb_writedata = (state == S_PIX_WR) && sprite_bit && !fb_readdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      n_q       <= '0;
      addr_q    <= '0;
      row       <= '0;
      col       <= '0;
      shreg     <= '0;
      mem_addr  <= '0;
      fb_addr_x <= '0;
      fb_addr_y <= '0;
      collision <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear_start) begin
            // Clear has priority; a coincident draw is dropped entirely.
            fb_addr_x <= '0;
            fb_addr_y <= '0;
            state     <= S_CLEAR;
          end else if (draw_start) begin
            x_q       <= sprite_x;
            y_q       <= sprite_y;
            n_q       <= sprite_n;
            addr_q    <= sprite_addr;
            row       <= '0;
            col       <= '0;
            collision <= 1'b0;
            if (sprite_n == 4'd0) begin
              state <= S_DONE;
            end else begin
              // Address for row 0 is presented during FETCH
              mem_addr <= sprite_addr;
              state    <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          state <= S_LATCH;
        end

        S_LATCH: begin
          shreg     <= mem_readdata;
          col       <= '0;
          fb_addr_x <= x_q;
          fb_addr_y <= y_q + {1'b0, row};
          state     <= S_PIX_RD;
        end

        S_PIX_RD: begin
          // Address already set up on entry; framebuffer read returns during PIX_WR
          state <= S_PIX_WR;
        end

        S_PIX_WR: begin
          if (sprite_bit && fb_readdata) begin
            collision <= 1'b1;
          end
          shreg <= {shreg[6:0], 1'b0};
          col   <= col + 3'd1;
          if (col != 3'd7) begin
            fb_addr_x <= x_q + {3'b000, col} + 6'd1;
            state     <= S_PIX_RD;
          end else if (last_row) begin
            state <= S_DONE;
          end else begin
            row      <= row + 4'd1;
            mem_addr <= addr_q + {8'h00, row} + 12'd1;
            state    <= S_FETCH;
          end
        end

        S_CLEAR: begin
          // x runs fastest; (63,31) is the final pixel
          fb_addr_x <= fb_addr_x + 6'd1;
          if (fb_addr_x == 6'd63) begin
            fb_addr_y <= fb_addr_y + 5'd1;
            if (fb_addr_y == 5'd31) begin
              state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_draw_ctrl.sv
// Purpose: directed self-checking bench for sprite_draw_ctrl with sprite memory and framebuffer models.
// Latency: measured in rising edges from the start-sampling edge to the edge where done is seen.
// Backpressure: n/a; models respond with fixed one-cycle read latency.
module tb_sprite_draw_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        draw_start = 1'b0;
  logic        clear_start = 1'b0;
  logic [5:0]  sprite_x = '0;
  logic [4:0]  sprite_y = '0;
  logic [3:0]  sprite_n = '0;
  logic [11:0] sprite_addr = '0;
  logic [11:0] mem_addr;
  logic [7:0]  mem_readdata = '0;
  logic [5:0]  fb_addr_x;
  logic [4:0]  fb_addr_y;
  logic        fb_writedata;
  logic        fb_WE;
  logic        fb_readdata = 1'b0;
  logic        busy;
  logic        done;
  logic        collision;

  logic [7:0]  mem [0:4095];
  logic        fb  [0:2047];
  logic [11:0] wq [$];   // {y, x, data} of every framebuffer write

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sprite_draw_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .draw_start   (draw_start),
    .clear_start  (clear_start),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .sprite_n     (sprite_n),
    .sprite_addr  (sprite_addr),
    .mem_addr     (mem_addr),
    .mem_readdata (mem_readdata),
    .fb_addr_x    (fb_addr_x),
    .fb_addr_y    (fb_addr_y),
    .fb_writedata (fb_writedata),
    .fb_WE        (fb_WE),
    .fb_readdata  (fb_readdata),
    .busy         (busy),
    .done         (done),
    .collision    (collision)
  );

  // Synchronous-read memory and framebuffer
  always @(posedge clk) begin
    mem_readdata <= mem[mem_addr];
    fb_readdata  <= fb[{fb_addr_y, fb_addr_x}];
  end

  // Writes are captured mid-cycle, away from the clock edge
  always @(negedge clk) begin
    if (reset && fb_WE) begin
      wq.push_back({fb_addr_y, fb_addr_x, fb_writedata});
      fb[{fb_addr_y, fb_addr_x}] <= fb_writedata;
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic clr, input logic drw, input logic [5:0] x, input logic [4:0] y,
                        input logic [3:0] n, input logic [11:0] a, output int lat);
    @(negedge clk);
    sprite_x    = x;
    sprite_y    = y;
    sprite_n    = n;
    sprite_addr = a;
    draw_start  = drw;
    clear_start = clr;
    wq.delete();
    @(negedge clk);
    draw_start  = 1'b0;
    clear_start = 1'b0;
    lat = 1;
    while (!done && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  logic [11:0] exp3 [0:7];

  initial begin
    int lat;
    int errs;
    int ones;
    int waits;

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    for (int i = 0; i < 2048; i++) fb[i] = 1'b0;
    mem[12'h200] = 8'h80;
    mem[12'h210] = 8'hF0;
    mem[12'h211] = 8'hF0;
    mem[12'h220] = 8'hFF;
    mem[12'h221] = 8'hFF;

    exp3[0] = {5'd31, 6'd62, 1'b1};
    exp3[1] = {5'd31, 6'd63, 1'b1};
    exp3[2] = {5'd31, 6'd0,  1'b1};
    exp3[3] = {5'd31, 6'd1,  1'b1};
    exp3[4] = {5'd0,  6'd62, 1'b1};
    exp3[5] = {5'd0,  6'd63, 1'b1};
    exp3[6] = {5'd0,  6'd0,  1'b1};
    exp3[7] = {5'd0,  6'd1,  1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_vec("rst_busy", busy, 0);
    check_vec("rst_done", done, 0);
    check_vec("rst_we", fb_WE, 0);
    check_vec("rst_memaddr", mem_addr, 0);
    check_vec("rst_fbx", fb_addr_x, 0);
    check_vec("rst_fby", fb_addr_y, 0);
    check_vec("rst_coll", collision, 0);
    reset = 1'b1;

    // Single pixel on blank screen
    run_op(0, 1, 6'd1, 5'd1, 4'd1, 12'h200, lat);
    check_vec("d1_lat", lat, 19);
    check_vec("d1_nwr", wq.size(), 1);
    if (wq.size() > 0) check_vec("d1_wr0", wq[0], {5'd1, 6'd1, 1'b1});
    check_vec("d1_coll", collision, 0);
    check_vec("d1_memaddr", mem_addr, 12'h200);

    // Same draw again erases the pixel and reports collision
    run_op(0, 1, 6'd1, 5'd1, 4'd1, 12'h200, lat);
    check_vec("d2_lat", lat, 19);
    check_vec("d2_nwr", wq.size(), 1);
    if (wq.size() > 0) check_vec("d2_wr0", wq[0], {5'd1, 6'd1, 1'b0});
    check_vec("d2_coll", collision, 1);

    // Clear and draw together: clear wins, draw dropped
    run_op(1, 1, 6'd5, 5'd5, 4'd3, 12'h210, lat);
    check_vec("clr_lat", lat, 2049);
    check_vec("clr_nwr", wq.size(), 2048);
    errs = 0;
    for (int i = 0; i < wq.size(); i++) begin
      logic [11:0] ev;
      logic [10:0] iv;
      iv = i[10:0];
      ev = {iv, 1'b0};
      if (wq[i] !== ev) errs++;
    end
    check_vec("clr_order", errs, 0);
    ones = 0;
    for (int i = 0; i < 2048; i++) if (fb[i] !== 1'b0) ones++;
    check_vec("clr_blank", ones, 0);
    check_vec("clr_coll", collision, 1);
    check_vec("clr_memaddr", mem_addr, 12'h200);

    // n=0 draw: immediate done, no accesses, collision cleared
    run_op(0, 1, 6'd3, 5'd3, 4'd0, 12'h210, lat);
    check_vec("n0_lat", lat, 1);
    check_vec("n0_nwr", wq.size(), 0);
    check_vec("n0_coll", collision, 0);
    check_vec("n0_memaddr", mem_addr, 12'h200);

    // Two rows wrapping in both x and y
    run_op(0, 1, 6'd62, 5'd31, 4'd2, 12'h210, lat);
    check_vec("wr_lat", lat, 37);
    check_vec("wr_nwr", wq.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < wq.size()) check_vec($sformatf("wr_w%0d", i), wq[i], exp3[i]);
    end
    check_vec("wr_coll", collision, 0);
    check_vec("wr_memaddr", mem_addr, 12'h211);

    // draw_start while busy is ignored
    @(negedge clk);
    sprite_x = 6'd5; sprite_y = 5'd5; sprite_n = 4'd1; sprite_addr = 12'h200;
    draw_start = 1'b1;
    wq.delete();
    @(negedge clk);
    draw_start = 1'b0;
    lat = 1;
    check_vec("bz_busy", busy, 1);
    repeat (3) begin @(negedge clk); lat++; end
    sprite_x = 6'd10; sprite_y = 5'd10; sprite_n = 4'd3; sprite_addr = 12'h220;
    draw_start = 1'b1;
    @(negedge clk);
    lat++;
    draw_start = 1'b0;
    while (!done && lat < 5000) begin @(negedge clk); lat++; end
    check_vec("bz_lat", lat, 19);
    check_vec("bz_nwr", wq.size(), 1);
    if (wq.size() > 0) check_vec("bz_wr0", wq[0], {5'd5, 6'd5, 1'b1});
    check_vec("bz_memaddr", mem_addr, 12'h200);

    // Reset during pixel 3 of row 1
    @(negedge clk);
    sprite_x = 6'd20; sprite_y = 5'd10; sprite_n = 4'd2; sprite_addr = 12'h220;
    draw_start = 1'b1;
    wq.delete();
    @(negedge clk);
    draw_start = 1'b0;
    waits = 0;
    while (wq.size() < 11 && waits < 200) begin
      @(negedge clk);
      #1;
      waits++;
    end
    check_vec("ra_reach", (wq.size() >= 11), 1);
    @(posedge clk); #1;   // PIX_RD of pixel 3
    @(posedge clk); #1;   // PIX_WR of pixel 3
    check_vec("ra_pre_we", fb_WE, 1);
    check_vec("ra_pre_busy", busy, 1);
    reset = 1'b0;
    #1;
    check_vec("ra_we", fb_WE, 0);
    check_vec("ra_busy", busy, 0);
    check_vec("ra_memaddr", mem_addr, 0);
    check_vec("ra_fbx", fb_addr_x, 0);
    @(negedge clk); #1;
    check_vec("ra_nwr", wq.size(), 11);
    @(negedge clk);
    reset = 1'b1;

    // Normal draw after the abort
    run_op(0, 1, 6'd1, 5'd1, 4'd1, 12'h200, lat);
    check_vec("pr_lat", lat, 19);
    check_vec("pr_nwr", wq.size(), 1);
    if (wq.size() > 0) check_vec("pr_wr0", wq[0], {5'd1, 6'd1, 1'b1});
    check_vec("pr_coll", collision, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
